function_arbiter: RTL

//  Shares one function_component datapath (out = (a|b) - b, i.e. a & ~b, 8-bit) between two requesters.

---
 rtl/function_arbiter_pkg.sv | 20 ++
 rtl/function_arbiter_if.sv | 30 +++
 rtl/function_arbiter_rr_arb2.sv | 11 +
 rtl/function_component.sv | 10 +
 rtl/function_arbiter.sv | 105 ++++++++++
 5 files changed

// File: rtl/function_arbiter_pkg.sv
// Shared types and constants for the two-requester function arbiter.
// State encodings are fixed so waveforms and external monitors can decode them.
package function_arbiter_pkg;

    localparam int WIDTH_DEF = 8;
    localparam int CNT_W_DEF = 16;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    // Reference form of the shared operation, used for documentation of intent only.
    function automatic logic [WIDTH_DEF-1:0] fc_ref(input logic [WIDTH_DEF-1:0] a,
                                                    input logic [WIDTH_DEF-1:0] b);
        return a & ~b;
    endfunction

endpackage

// File: rtl/function_arbiter_if.sv
// Handshake bundle between the two operand producers, the result consumer and the arbiter.
interface function_arbiter_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
);
    logic             req0_valid;
    logic [WIDTH-1:0] req0_a;
    logic [WIDTH-1:0] req0_b;
    logic             req0_ready;
    logic             req1_valid;
    logic [WIDTH-1:0] req1_a;
    logic [WIDTH-1:0] req1_b;
    logic             req1_ready;
    logic             res_valid;
    logic [WIDTH-1:0] res_data;
    logic             res_id;
    logic             res_ready;
    logic             busy;
    logic [CNT_W-1:0] op_count;

    modport slave (
        input  req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b, res_ready,
        output req0_ready, req1_ready, res_valid, res_data, res_id, busy, op_count
    );

    modport master (
        output req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b, res_ready,
        input  req0_ready, req1_ready, res_valid, res_data, res_id, busy, op_count
    );
endinterface

// File: rtl/function_arbiter_rr_arb2.sv
// Combinational two-way round-robin grant; the requester not served last wins a tie.
module rr_arb2 (
    input  logic valid0,
    input  logic valid1,
    input  logic last_grant,
    output logic grant_vld,
    output logic grant_id
);
    assign grant_vld = valid0 | valid1;
    assign grant_id  = (valid0 & valid1) ? ~last_grant : valid1;
endmodule

// File: rtl/function_component.sv
// Shared datapath: out = (a|b) - b, which equals a & ~b; the borrow-out is dropped.
module function_component #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] out
);
    assign out = (a | b) - b;
endmodule

// File: rtl/function_arbiter.sv
// Shares one function_component between two requesters: round-robin accept,
// one-cycle execute, result held until the consumer takes it, completed-op counter.
module function_arbiter
    import function_arbiter_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input logic               clk,
    input logic               rst,
    function_arbiter_if.slave bus
);

    state_t           state;
    state_t           state_next;
    logic             last_grant;
    logic             grant_vld;
    logic             grant_id;
    logic             accept;
    logic [WIDTH-1:0] op_a_p0;
    logic [WIDTH-1:0] op_b_p0;
    logic             op_id_p0;
    logic [WIDTH-1:0] fc_out;
    logic             res_valid_p1;
    logic [WIDTH-1:0] res_data_p1;
    logic             res_id_p1;
    logic [CNT_W-1:0] op_count;

    rr_arb2 u_arb (
        .valid0     (bus.req0_valid),
        .valid1     (bus.req1_valid),
        .last_grant (last_grant),
        .grant_vld  (grant_vld),
        .grant_id   (grant_id)
    );

    function_component #(.WIDTH(WIDTH)) u_fc (
        .a   (op_a_p0),
        .b   (op_b_p0),
        .out (fc_out)
    );

    assign accept         = (state == S_IDLE) & grant_vld;
    assign bus.req0_ready = accept & ~grant_id;
    assign bus.req1_ready = accept & grant_id;
    assign bus.res_valid  = res_valid_p1;
    assign bus.res_data   = res_data_p1;
    assign bus.res_id     = res_id_p1;
    assign bus.busy       = (state != S_IDLE);
    assign bus.op_count   = op_count;

    always_comb begin
        state_next = S_IDLE;
        case (state)
            S_IDLE:  state_next = accept ? S_EXEC : S_IDLE;
            S_EXEC:  state_next = S_RESP;
            S_RESP:  state_next = bus.res_ready ? S_IDLE : S_RESP;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_next;
    end

    // Operand capture (p0) and result register (p1); reset also clears data so an
    // aborted operation leaves nothing behind.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant   <= 1'b1;
            op_a_p0      <= '0;
            op_b_p0      <= '0;
            op_id_p0     <= 1'b0;
            res_valid_p1 <= 1'b0;
            res_data_p1  <= '0;
            res_id_p1    <= 1'b0;
            op_count     <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        op_a_p0    <= grant_id ? bus.req1_a : bus.req0_a;
                        op_b_p0    <= grant_id ? bus.req1_b : bus.req0_b;
                        op_id_p0   <= grant_id;
                        last_grant <= grant_id;
                    end
                end
                S_EXEC: begin
                    res_data_p1  <= fc_out;
                    res_id_p1    <= op_id_p0;
                    res_valid_p1 <= 1'b1;
                end
                S_RESP: begin
                    if (bus.res_ready) begin
                        res_valid_p1 <= 1'b0;
                        op_count     <= op_count + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
